// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: bundles the three handshakes of the load/store controller.
//   req_* : execute -> controller request (valid/ready)
//   mem_* : controller -> data memory access (req/ack)
//   rsp_* : controller -> L_type / writeback response (valid/ready)
// Modports:
//   slave  : the controller's view (takes requests, drives memory and responses)
//   master : the surrounding pipeline/memory view (drives requests, ack, rsp_ready)
interface lsu_mem_ctrl_if;
  // Request from execute
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // Response to L_type / writeback
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_is_load;
  logic [2:0]  rsp_funct3;
  logic [31:0] rsp_daddr;
  logic [31:0] rsp_drdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata,
    output rsp_valid, rsp_is_load, rsp_funct3, rsp_daddr, rsp_drdata, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata,
    input  rsp_valid, rsp_is_load, rsp_funct3, rsp_daddr, rsp_drdata, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store memory-access controller feeding the L_type stage.
// Accepts one load/store at a time, checks funct3 legality and alignment,
// runs a req/ack access on the data-memory bus (byte enables, lane-replicated
// store data, timeout abort), then presents raw read word, byte address and
// funct3 as a response held until accepted.
// Ports:
//   clk   : clock, all state updates on rising edge
//   reset : synchronous, active-high reset
//   bus   : lsu_mem_ctrl_if.slave (req_*, mem_*, rsp_* handshakes)
// Parameters:
//   TIMEOUT : mem_req cycles without mem_ack before abort with error (>= 1)
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  lsu_mem_ctrl_if.slave    bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;

  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_wdata;

  logic               r_rsp_is_load;
  logic [2:0]         r_rsp_funct3;
  logic [31:0]        r_rsp_daddr;
  logic [31:0]        r_rsp_drdata;
  logic               r_rsp_err;

  logic               w_accept;
  logic               w_illegal;
  logic               w_misaligned;
  logic               w_req_err;
  logic               w_tc;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;

  // Request decode: legality, alignment, byte enables, replicated store data
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    w_be         = '0;
    w_wdata      = '0;

    if (bus.req_we) begin
      w_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

    // funct3[1:0] encodes access size for every legal code
    unique case (bus.req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = bus.req_addr[0];
        w_be         = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_misaligned = (bus.req_addr[1:0] != 2'b00);
        w_be         = 4'b1111;
        w_wdata      = bus.req_wdata;
      end
      default: begin
        w_be    = '0;
        w_wdata = '0;
      end
    endcase

    if (!bus.req_we) begin
      w_wdata = '0;
    end
  end

  assign w_req_err = w_illegal || w_misaligned;
  assign w_accept  = bus.req_valid && (r_state == IDLE);
  assign w_tc      = (r_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ack || w_tc) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory-bus and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_be      <= '0;
      r_mem_wdata   <= '0;
      r_rsp_is_load <= 1'b0;
      r_rsp_funct3  <= '0;
      r_rsp_daddr   <= '0;
      r_rsp_drdata  <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rsp_funct3  <= bus.req_funct3;
            r_rsp_daddr   <= bus.req_addr;
            r_rsp_is_load <= !bus.req_we;
            r_rsp_drdata  <= '0;
            r_rsp_err     <= w_req_err;
            r_cnt         <= '0;
            if (!w_req_err) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.req_we;
              r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over the terminal count
          if (bus.mem_ack) begin
            r_rsp_drdata <= r_rsp_is_load ? bus.mem_rdata : '0;
            r_rsp_err    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
          end else if (w_tc) begin
            r_rsp_drdata <= '0;
            r_rsp_err    <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready   = (r_state == IDLE);
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_be      = r_mem_be;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.rsp_valid   = (r_state == RESP);
  assign bus.rsp_is_load = r_rsp_is_load;
  assign bus.rsp_funct3  = r_rsp_funct3;
  assign bus.rsp_daddr   = r_rsp_daddr;
  assign bus.rsp_drdata  = r_rsp_drdata;
  assign bus.rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl (TIMEOUT=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_lsu_mem_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, ".req_ready"},   32'(bus.req_ready),   32'd1);
    chk_eq({tag, ".mem_req"},     32'(bus.mem_req),     32'd0);
    chk_eq({tag, ".mem_we"},      32'(bus.mem_we),      32'd0);
    chk_eq({tag, ".mem_addr"},    bus.mem_addr,         32'd0);
    chk_eq({tag, ".mem_be"},      32'(bus.mem_be),      32'd0);
    chk_eq({tag, ".mem_wdata"},   bus.mem_wdata,        32'd0);
    chk_eq({tag, ".rsp_valid"},   32'(bus.rsp_valid),   32'd0);
    chk_eq({tag, ".rsp_is_load"}, 32'(bus.rsp_is_load), 32'd0);
    chk_eq({tag, ".rsp_funct3"},  32'(bus.rsp_funct3),  32'd0);
    chk_eq({tag, ".rsp_daddr"},   bus.rsp_daddr,        32'd0);
    chk_eq({tag, ".rsp_drdata"},  bus.rsp_drdata,       32'd0);
    chk_eq({tag, ".rsp_err"},     32'(bus.rsp_err),     32'd0);
  endtask

  // Present one request for one edge (the accept edge)
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    chk_eq({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  // Serve the memory access; ack_after = wait cycles before ack (-1 = never).
  // Checks bus fields every mem_req cycle and bounds the wait for rsp_valid.
  task automatic run_access(input string tag, input int ack_after,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input logic e_we,
                            output int req_cycles, output int ticks);
    req_cycles = 0;
    ticks      = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) break;
      if (bus.mem_req) begin
        req_cycles++;
        chk_eq({tag, ".mem_addr"},  bus.mem_addr,     e_addr);
        chk_eq({tag, ".mem_be"},    32'(bus.mem_be),  32'(e_be));
        chk_eq({tag, ".mem_wdata"}, bus.mem_wdata,    e_wdata);
        chk_eq({tag, ".mem_we"},    32'(bus.mem_we),  32'(e_we));
        bus.mem_ack = (ack_after >= 0) && (req_cycles == ack_after + 1);
      end
      tick();
      ticks++;
      bus.mem_ack = 1'b0;
    end
    chk_eq({tag, ".rsp_valid_bound"}, 32'(bus.rsp_valid), 32'd1);
    chk_eq({tag, ".mem_req_after"},   32'(bus.mem_req),   32'd0);
    chk_eq({tag, ".mem_be_after"},    32'(bus.mem_be),    32'd0);
  endtask

  task automatic release_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk_eq({tag, ".rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk_eq({tag, ".req_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    issue(tag, we, f3, addr, 32'hFFFF_FFFF);
    chk_eq({tag, ".rsp_valid"},  32'(bus.rsp_valid),  32'd1);
    chk_eq({tag, ".rsp_err"},    32'(bus.rsp_err),    32'd1);
    chk_eq({tag, ".rsp_drdata"}, bus.rsp_drdata,      32'd0);
    chk_eq({tag, ".mem_req"},    32'(bus.mem_req),    32'd0);
    release_rsp(tag);
    chk_eq({tag, ".mem_req_idle"}, 32'(bus.mem_req), 32'd0);
  endtask

  int rc;
  int tk;

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    bus.rsp_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    // 1: LB at byte lane 2, ack in the first mem_req cycle
    bus.mem_rdata = 32'hFF7F_FFF0;
    issue("lb", 1'b0, 3'b000, 32'h0010_0002, 32'h0);
    run_access("lb", 0, 32'h0010_0000, 4'b0100, 32'h0, 1'b0, rc, tk);
    chk_eq("lb.req_cycles", 32'(rc), 32'd1);
    chk_eq("lb.latency",    32'(tk), 32'd1);
    chk_eq("lb.rsp_drdata", bus.rsp_drdata, 32'hFF7F_FFF0);
    chk_eq("lb.rsp_daddr",  bus.rsp_daddr,  32'h0010_0002);
    chk_eq("lb.rsp_funct3", 32'(bus.rsp_funct3), 32'd0);
    chk_eq("lb.rsp_err",    32'(bus.rsp_err),    32'd0);
    chk_eq("lb.rsp_is_load", 32'(bus.rsp_is_load), 32'd1);
    release_rsp("lb");

    // 2: SH upper half, ack after 3 wait cycles (also the terminal-count cycle)
    bus.mem_rdata = 32'hDEAD_BEEF;
    issue("sh", 1'b1, 3'b001, 32'h0000_0206, 32'h0000_ABCD);
    run_access("sh", 3, 32'h0000_0204, 4'b1100, 32'hABCD_ABCD, 1'b1, rc, tk);
    chk_eq("sh.req_cycles",  32'(rc), 32'd4);
    chk_eq("sh.rsp_is_load", 32'(bus.rsp_is_load), 32'd0);
    chk_eq("sh.rsp_err",     32'(bus.rsp_err),     32'd0);
    chk_eq("sh.rsp_drdata",  bus.rsp_drdata,       32'd0);
    chk_eq("sh.rsp_funct3",  32'(bus.rsp_funct3),  32'd1);
    release_rsp("sh");

    // SB at byte lane 3: replicated byte
    issue("sb", 1'b1, 3'b000, 32'h0000_0007, 32'h1234_565A);
    run_access("sb", 1, 32'h0000_0004, 4'b1000, 32'h5A5A_5A5A, 1'b1, rc, tk);
    chk_eq("sb.rsp_err", 32'(bus.rsp_err), 32'd0);
    release_rsp("sb");

    // 3: error requests go straight to RESP
    err_case("lw_mis",  1'b0, 3'b010, 32'h0000_0101);
    err_case("ld_f011", 1'b0, 3'b011, 32'h0000_0000);
    err_case("st_f100", 1'b1, 3'b100, 32'h0000_0000);
    err_case("sh_mis",  1'b1, 3'b001, 32'h0000_0003);

    // 4: LHU timeout, then ack on the terminal cycle
    issue("lhu_to", 1'b0, 3'b101, 32'h0000_0010, 32'h0);
    run_access("lhu_to", -1, 32'h0000_0010, 4'b0011, 32'h0, 1'b0, rc, tk);
    chk_eq("lhu_to.req_cycles", 32'(rc), 32'd4);
    chk_eq("lhu_to.rsp_err",    32'(bus.rsp_err), 32'd1);
    chk_eq("lhu_to.rsp_drdata", bus.rsp_drdata,   32'd0);
    release_rsp("lhu_to");

    bus.mem_rdata = 32'h8001_7FFE;
    issue("lhu_ack", 1'b0, 3'b101, 32'h0000_0010, 32'h0);
    run_access("lhu_ack", 3, 32'h0000_0010, 4'b0011, 32'h0, 1'b0, rc, tk);
    chk_eq("lhu_ack.req_cycles", 32'(rc), 32'd4);
    chk_eq("lhu_ack.rsp_err",    32'(bus.rsp_err), 32'd0);
    chk_eq("lhu_ack.rsp_drdata", bus.rsp_drdata,   32'h8001_7FFE);
    release_rsp("lhu_ack");

    // 5: response back-pressure with a pending request
    bus.mem_rdata = 32'h0BAD_F00D;
    issue("bp", 1'b0, 3'b100, 32'h0000_0031, 32'h0);
    run_access("bp", 0, 32'h0000_0030, 4'b0010, 32'h0, 1'b0, rc, tk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0020;
    bus.req_wdata  = 32'h1122_3344;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_eq("bp.rsp_valid",  32'(bus.rsp_valid),  32'd1);
      chk_eq("bp.req_ready",  32'(bus.req_ready),  32'd0);
      chk_eq("bp.mem_req",    32'(bus.mem_req),    32'd0);
      chk_eq("bp.rsp_drdata", bus.rsp_drdata,      32'h0BAD_F00D);
      chk_eq("bp.rsp_daddr",  bus.rsp_daddr,       32'h0000_0031);
      chk_eq("bp.rsp_funct3", 32'(bus.rsp_funct3), 32'd4);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk_eq("bp.idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk_eq("bp.idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk_eq("bp.idle_mem_req",   32'(bus.mem_req),   32'd0);
    tick();
    bus.req_valid = 1'b0;
    run_access("sw", 0, 32'h0000_0020, 4'b1111, 32'h1122_3344, 1'b1, rc, tk);
    chk_eq("sw.req_cycles", 32'(rc), 32'd1);
    chk_eq("sw.rsp_daddr",  bus.rsp_daddr, 32'h0000_0020);
    release_rsp("sw");

    // 6: reset during ACCESS cycle 2, late ack ignored
    issue("rst", 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    chk_eq("rst.mem_req_c1", 32'(bus.mem_req), 32'd1);
    tick();
    chk_eq("rst.mem_req_c2", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("rst_mid");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    tick();
    bus.mem_ack = 1'b0;
    chk_reset_vals("rst_late_ack");
    tick();
    chk_eq("rst.rsp_valid_later", 32'(bus.rsp_valid), 32'd0);
    chk_eq("rst.req_ready_later", 32'(bus.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store memory-access controller that sits directly upstream of the L_type load-extract stage. It accepts one load or store request at a time from execute over a valid/ready handshake and checks alignment. It drives the data-memory bus with a req/ack handshake, including byte enables and lane-replicated store data. It then presents the raw word (drdata), the original byte address (daddr) and funct3 to L_type, which does the sign/zero extension.

Parameters:
TIMEOUT, 16, number of mem_req cycles without mem_ack before the access is aborted with an error (must be >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request valid from execute
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data (low bytes significant)
mem_req  output  1  memory request, held until ack or timeout
mem_we  output  1  memory write enable
mem_addr  output  32  word address, bits [1:0] forced to 0
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completes the access this cycle
mem_rdata  input  32  read word, valid with mem_ack
rsp_valid  output  1  response valid to L_type/writeback
rsp_ready  input  1  consumer accepts response
rsp_is_load  output  1  response belongs to a load
rsp_funct3  output  3  latched funct3
rsp_daddr  output  32  latched byte address
rsp_drdata  output  32  captured read word (0 for stores/errors)
rsp_err  output  1  misaligned, illegal funct3 or timeout

Behaviour:
- Only the clock and reset are fixed: one clock; reset is synchronous and active-high.
- Reset: state IDLE. req_ready=1. mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid and all rsp_* are 0. The timeout counter is 0.
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid && req_ready && !reset.
- FSM IDLE -> ACCESS -> RESP -> IDLE. Error requests go IDLE -> RESP directly.
- Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010. Any other value is an error.
- Misalignment: halfword (001/101) with addr[0]=1, or word (010) with addr[1:0]!=0, is an error.
- Accept with error: next cycle RESP, rsp_err=1, rsp_drdata=0, mem_req never asserted.
- Accept without error: latch funct3, addr, we and is_load. Next cycle ACCESS with mem_req=1.
- Byte enables:
  - byte: mem_be = 1<<addr[1:0], mem_wdata = {4{wdata[7:0]}}
  - half: mem_be = addr[1] ? 1100 : 0011, mem_wdata = {2{wdata[15:0]}}
  - word: mem_be = 1111, mem_wdata = wdata
  - loads use the same mem_be with mem_wdata=0 and mem_we=0
- ACCESS: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until the access terminates.
  - mem_ack=1: capture mem_rdata into rsp_drdata if load, else 0. Go RESP with err=0.
  - Counter cleared on entry to ACCESS and incremented each ACCESS cycle without ack.
  - Counter == TIMEOUT-1 with no ack: abort, go RESP with err=1, rsp_drdata=0. mem_req is therefore high for exactly TIMEOUT cycles.
  - mem_ack on the terminal-count cycle: ack wins, no error.
- Leaving ACCESS: mem_req, mem_we and mem_be return to 0 on the same edge.
- RESP: rsp_valid=1. All rsp_* stay stable until rsp_ready=1, then IDLE and rsp_valid=0 on the next edge. No bypass: a new request is accepted no earlier than the cycle after the response handshake.
- Latency: accept at edge T, mem_req high in cycle T..T+1. Ack in the first mem_req cycle gives rsp_valid in the following cycle (2 cycles accept-to-response minimum).
- mem_ack while not in ACCESS is ignored.
- Reset mid-operation (any state): next edge returns to reset values. A pending access or response is discarded and a late mem_ack is ignored.

Test Plan:
1. LB, req_addr=0x00100002, mem_ack in the first mem_req cycle with mem_rdata=0xFF7FFFF0 -> mem_addr=0x00100000, mem_be=0100, mem_we=0. Then rsp_valid with rsp_drdata=0xFF7FFFF0, rsp_daddr=0x00100002, rsp_funct3=000, rsp_err=0, two cycles after accept.
2. SH, addr=0x00000206, wdata=0x0000ABCD, ack after 3 wait cycles -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1. mem_req high 4 cycles, then rsp_valid with rsp_is_load=0, rsp_err=0.
3. LW addr=0x00000101; then load funct3=011 -> each gives rsp_err=1 one cycle after accept and mem_req never asserted.
4. TIMEOUT=4, LHU addr=0x00000010, no ack -> mem_req high exactly 4 cycles, then rsp_err=1, rsp_drdata=0. Repeat with ack on the 4th cycle -> rsp_err=0.
5. rsp_ready low for 3 cycles while req_valid=1 -> rsp_* stable, req_ready=0, no new mem_req. rsp_ready=1 -> IDLE next cycle, pending request accepted one cycle later.
6. reset asserted in ACCESS cycle 2, mem_ack pulsed in the cycle after reset deasserts -> mem_req=0 and all outputs at reset values after the edge, no rsp_valid, req_ready=1.
